// File: rtl/imem_arbiter.sv
// Two-port arbiter for the instruction memory read port: fetch (F) has priority,
// and a starvation counter forces a data-side (D) grant. Optional stats: IMEM_ARB_STATS_EN.
module imem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int F_BURST_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              f_req_i,
    input  logic [ADDR_W-1:0] f_addr_i,
    output logic              f_gnt_o,
    output logic              f_rvalid_o,
    output logic [DATA_W-1:0] f_rdata_o,
    output logic              f_err_o,
    input  logic              d_req_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i
`ifdef IMEM_ARB_STATS_EN
    ,
    output logic [31:0]       conflict_cnt_o,
    output logic [31:0]       forced_cnt_o
`endif
);

    localparam logic [7:0] BURST_MAX = 8'(F_BURST_MAX);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_F,
        OWN_D
    } owner_t;

    owner_t            owner_reg;
    logic              err_reg;
    logic [7:0]        starve_cnt_reg;
    logic [DATA_W-1:0] f_hold_reg;
    logic [DATA_W-1:0] d_hold_reg;
    logic [DATA_W-1:0] resp_data;
    logic              gnt_misaligned;

    // Grants are suppressed while reset is asserted so nothing reaches memory.
    always_comb begin
        f_gnt_o    = 1'b0;
        d_gnt_o    = 1'b0;
        mem_addr_o = '0;
        if (rst_ni) begin
            if (f_req_i && !(d_req_i && starve_cnt_reg == BURST_MAX)) begin
                f_gnt_o = 1'b1;
            end else if (d_req_i) begin
                d_gnt_o = 1'b1;
            end
        end
        if (f_gnt_o) begin
            mem_addr_o = f_addr_i;
        end else if (d_gnt_o) begin
            mem_addr_o = d_addr_i;
        end
    end

    assign gnt_misaligned = (mem_addr_o[1:0] != 2'b00);

    // Misaligned responses return zero instead of whatever the memory produced.
    assign resp_data  = err_reg ? '0 : mem_data_i;
    assign f_rvalid_o = rst_ni && (owner_reg == OWN_F);
    assign d_rvalid_o = rst_ni && (owner_reg == OWN_D);
    assign f_err_o    = f_rvalid_o && err_reg;
    assign d_err_o    = d_rvalid_o && err_reg;
    assign f_rdata_o  = !rst_ni ? '0 : (f_rvalid_o ? resp_data : f_hold_reg);
    assign d_rdata_o  = !rst_ni ? '0 : (d_rvalid_o ? resp_data : d_hold_reg);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            owner_reg      <= OWN_NONE;
            err_reg        <= 1'b0;
            starve_cnt_reg <= '0;
            f_hold_reg     <= '0;
            d_hold_reg     <= '0;
        end else begin
            if (f_gnt_o) begin
                owner_reg <= OWN_F;
            end else if (d_gnt_o) begin
                owner_reg <= OWN_D;
            end else begin
                owner_reg <= OWN_NONE;
            end
            err_reg <= gnt_misaligned;

            if (d_gnt_o || !d_req_i) begin
                starve_cnt_reg <= '0;
            end else if (f_gnt_o && starve_cnt_reg != BURST_MAX) begin
                starve_cnt_reg <= starve_cnt_reg + 8'd1;
            end

            if (f_rvalid_o) begin
                f_hold_reg <= resp_data;
            end
            if (d_rvalid_o) begin
                d_hold_reg <= resp_data;
            end
        end
    end

`ifdef IMEM_ARB_STATS_EN
    logic [31:0] conflict_cnt_reg;
    logic [31:0] forced_cnt_reg;

    // A D grant while F is also requesting can only come from the starve limit.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            conflict_cnt_reg <= '0;
            forced_cnt_reg   <= '0;
        end else begin
            if (f_req_i && d_req_i && conflict_cnt_reg != 32'hFFFF_FFFF) begin
                conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
            end
            if (d_gnt_o && f_req_i && forced_cnt_reg != 32'hFFFF_FFFF) begin
                forced_cnt_reg <= forced_cnt_reg + 32'd1;
            end
        end
    end

    assign conflict_cnt_o = conflict_cnt_reg;
    assign forced_cnt_o   = forced_cnt_reg;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_imem_arbiter;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = '0;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        f_err;
    logic        d_req = 1'b0;
    logic [31:0] d_addr = '0;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_data = '0;
`ifdef IMEM_ARB_STATS_EN
    logic [31:0] conflict_cnt;
    logic [31:0] forced_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    imem_arbiter #(.ADDR_W(32), .DATA_W(32), .F_BURST_MAX(MAXB)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .f_req_i    (f_req),
        .f_addr_i   (f_addr),
        .f_gnt_o    (f_gnt),
        .f_rvalid_o (f_rvalid),
        .f_rdata_o  (f_rdata),
        .f_err_o    (f_err),
        .d_req_i    (d_req),
        .d_addr_i   (d_addr),
        .d_gnt_o    (d_gnt),
        .d_rvalid_o (d_rvalid),
        .d_rdata_o  (d_rdata),
        .d_err_o    (d_err),
        .mem_addr_o (mem_addr),
        .mem_data_i (mem_data)
`ifdef IMEM_ARB_STATS_EN
        ,
        .conflict_cnt_o (conflict_cnt),
        .forced_cnt_o   (forced_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // Instruction memory: synchronous read, one-cycle latency.
    always @(posedge clk) mem_data <= memf(mem_addr);

    // Requesters must hold their address while waiting for a grant.
    logic        pf_req = 1'b0, pf_gnt = 1'b0, pd_req = 1'b0, pd_gnt = 1'b0;
    logic [31:0] pf_addr = '0, pd_addr = '0;
    always @(posedge clk) begin
        if (rst_n && pf_req && !pf_gnt && f_req)
            assert (f_addr == pf_addr) else $error("protocol: f_addr changed while waiting");
        if (rst_n && pd_req && !pd_gnt && d_req)
            assert (d_addr == pd_addr) else $error("protocol: d_addr changed while waiting");
        pf_req <= f_req; pf_gnt <= f_gnt; pf_addr <= f_addr;
        pd_req <= d_req; pd_gnt <= d_gnt; pd_addr <= d_addr;
    end

    // Reference model: pending transaction, D wait streak, last delivered data.
    int          starve = 0;
    bit          pv = 0, pd = 0;
    logic [31:0] paddr = '0, hold_f = '0, hold_d = '0;
    bit          a_rst = 0, a_f = 0, a_d = 0;
    longint      conf_m = 0, forced_m = 0;
    bit          e_fg, e_dg, e_frv, e_drv, e_fer, e_der;
    logic [31:0] e_maddr, e_frd, e_drd;

    task automatic commit();
        if (!a_rst) begin
            hold_f = '0; hold_d = '0; starve = 0; pv = 0; pd = 0;
            conf_m = 0; forced_m = 0;
        end else begin
            if (e_frv) hold_f = e_frd;
            if (e_drv) hold_d = e_drd;
            pv = e_fg || e_dg; pd = e_dg; paddr = e_maddr;
            if (e_dg || !a_d) starve = 0;
            else if (e_fg && starve < MAXB) starve++;
            if (a_f && a_d) conf_m++;
            if (e_dg && a_f) forced_m++;
        end
    endtask

    task automatic drive(input bit r, input bit f, input logic [31:0] fa,
                         input bit d, input logic [31:0] da);
        logic [31:0] rd;
        bit          mis;
        @(negedge clk);
        commit();
        rst_n = r; f_req = f; f_addr = fa; d_req = d; d_addr = da;
        #1;
        e_fg = 0; e_dg = 0;
        if (r) begin
            if (f && !(d && starve == MAXB)) e_fg = 1;
            else if (d) e_dg = 1;
        end
        e_maddr = e_fg ? fa : (e_dg ? da : 32'h0);
        mis   = (paddr[1:0] != 2'b00);
        rd    = mis ? 32'h0 : memf(paddr);
        e_frv = r && pv && !pd;
        e_drv = r && pv && pd;
        e_fer = e_frv && mis;
        e_der = e_drv && mis;
        e_frd = !r ? 32'h0 : (e_frv ? rd : hold_f);
        e_drd = !r ? 32'h0 : (e_drv ? rd : hold_d);
        a_rst = r; a_f = f; a_d = d;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 32'h40, 1, 32'h80);
            n_cmp++;
            if ({f_gnt, d_gnt, f_rvalid, d_rvalid, f_err, d_err} !== 6'b0) begin
                n_bad++; $display("FAIL reset_ctrl: got %b want 000000", {f_gnt, d_gnt, f_rvalid, d_rvalid, f_err, d_err});
            end
            n_cmp++;
            if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        end
        drive(1, 0, 0, 0, 0);
        n_cmp++;
        if ({f_rdata, d_rdata} !== 64'h0) begin n_bad++; $display("FAIL reset_rdata: got %h %h want 0", f_rdata, d_rdata); end
    endtask

    task automatic test_f_only();
        drive(1, 1, 32'h10, 0, 0);
        n_cmp++;
        if (f_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_addr !== 32'h10) begin
            n_bad++; $display("FAIL f_only_gnt: got f=%b d=%b addr=%h want 1 0 00000010", f_gnt, d_gnt, mem_addr);
        end
        drive(1, 0, 0, 0, 0);
        n_cmp++;
        if (f_rvalid !== 1'b1 || f_rdata !== memf(32'h10) || f_err !== 1'b0 || d_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL f_only_resp: got v=%b data=%h err=%b dv=%b want 1 %h 0 0", f_rvalid, f_rdata, f_err, d_rvalid, memf(32'h10));
        end
        drive(1, 0, 0, 0, 0);
        n_cmp++;
        if (f_rvalid !== 1'b0 || f_rdata !== memf(32'h10)) begin
            n_bad++; $display("FAIL f_only_hold: got v=%b data=%h want 0 %h", f_rvalid, f_rdata, memf(32'h10));
        end
    endtask

    task automatic test_priority_burst();
        logic [31:0] fa = 32'h100, da = 32'h200;
        bit          prev_d = 0;
        for (int i = 0; i < 15; i++) begin
            bit want_d;
            want_d = (i % 5 == 4);
            drive(1, 1, fa, 1, da);
            n_cmp++;
            if (f_gnt !== !want_d || d_gnt !== want_d) begin
                n_bad++; $display("FAIL burst_gnt[%0d]: got f=%b d=%b want f=%b d=%b", i, f_gnt, d_gnt, !want_d, want_d);
            end
            n_cmp++;
            if (d_rvalid !== prev_d || f_rvalid !== (i != 0 && !prev_d)) begin
                n_bad++; $display("FAIL burst_rvalid[%0d]: got f=%b d=%b want f=%b d=%b", i, f_rvalid, d_rvalid, (i != 0 && !prev_d), prev_d);
            end
            if (want_d) da += 4; else fa += 4;
            prev_d = want_d;
        end
        drive(1, 0, 0, 0, 0);
    endtask

    task automatic test_d_misaligned();
        drive(1, 0, 0, 1, 32'h22);
        n_cmp++;
        if (d_gnt !== 1'b1 || f_gnt !== 1'b0 || mem_addr !== 32'h22) begin
            n_bad++; $display("FAIL d_mis_gnt: got d=%b f=%b addr=%h want 1 0 00000022", d_gnt, f_gnt, mem_addr);
        end
        drive(1, 0, 0, 0, 0);
        n_cmp++;
        if (d_rvalid !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0 || f_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL d_mis_resp: got v=%b err=%b data=%h fv=%b want 1 1 0 0", d_rvalid, d_err, d_rdata, f_rvalid);
        end
        drive(1, 0, 0, 0, 0);
        n_cmp++;
        if (d_err !== 1'b0 || d_rdata !== 32'h0) begin
            n_bad++; $display("FAIL d_mis_after: got err=%b data=%h want 0 0", d_err, d_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'h8};
        bit          is_d  [3] = '{0, 1, 0};
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(1, !is_d[i], addrs[i], is_d[i], addrs[i]);
            else       drive(1, 0, 0, 0, 0);
            if (i > 0) begin
                n_cmp++;
                if (f_rvalid !== !is_d[i-1] || d_rvalid !== is_d[i-1]) begin
                    n_bad++; $display("FAIL b2b_valid[%0d]: got f=%b d=%b want f=%b d=%b", i, f_rvalid, d_rvalid, !is_d[i-1], is_d[i-1]);
                end
                n_cmp++;
                if ((is_d[i-1] ? d_rdata : f_rdata) !== memf(addrs[i-1])) begin
                    n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, is_d[i-1] ? d_rdata : f_rdata, memf(addrs[i-1]));
                end
            end
        end
    endtask

    task automatic test_reset_inflight();
        drive(1, 1, 32'h30, 0, 0);
        n_cmp++;
        if (f_gnt !== 1'b1) begin n_bad++; $display("FAIL inflight_gnt: got %b want 1", f_gnt); end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0);
            n_cmp++;
            if ({f_gnt, d_gnt, f_rvalid, d_rvalid, f_err, d_err} !== 6'b0 || {f_rdata, d_rdata} !== 64'h0 || mem_addr !== 32'h0) begin
                n_bad++; $display("FAIL inflight_reset[%0d]: got ctl=%b fd=%h dd=%h addr=%h want all 0", i,
                                  {f_gnt, d_gnt, f_rvalid, d_rvalid, f_err, d_err}, f_rdata, d_rdata, mem_addr);
            end
        end
        drive(1, 0, 0, 0, 0);
        n_cmp++;
        if (f_rvalid !== 1'b0 || f_rdata !== 32'h0) begin
            n_bad++; $display("FAIL inflight_release: got v=%b data=%h want 0 0", f_rvalid, f_rdata);
        end
    endtask

    task automatic test_random();
        bit          f_on = 0, d_on = 0, r;
        logic [31:0] fa = '0, da = '0;
        for (int i = 0; i < 400; i++) begin
            if (!f_on && $urandom_range(0, 2) != 0) begin
                f_on = 1;
                fa = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
                if ($urandom_range(0, 7) == 0) fa[1:0] = 2'($urandom_range(1, 3));
            end
            if (!d_on && $urandom_range(0, 2) != 0) begin
                d_on = 1;
                da = {20'h1, 10'($urandom_range(0, 1023)), 2'b00};
                if ($urandom_range(0, 5) == 0) da[1:0] = 2'($urandom_range(1, 3));
            end
            r = ($urandom_range(0, 59) != 0);
            drive(r, f_on, fa, d_on, da);
            n_cmp++;
            if (f_gnt !== e_fg || d_gnt !== e_dg) begin
                n_bad++; $display("FAIL rnd_gnt[%0d]: got f=%b d=%b want f=%b d=%b", i, f_gnt, d_gnt, e_fg, e_dg);
            end
            n_cmp++;
            if (mem_addr !== e_maddr) begin n_bad++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, mem_addr, e_maddr); end
            n_cmp++;
            if (f_rvalid !== e_frv || f_err !== e_fer || f_rdata !== e_frd) begin
                n_bad++; $display("FAIL rnd_f_resp[%0d]: got v=%b e=%b d=%h want v=%b e=%b d=%h", i, f_rvalid, f_err, f_rdata, e_frv, e_fer, e_frd);
            end
            n_cmp++;
            if (d_rvalid !== e_drv || d_err !== e_der || d_rdata !== e_drd) begin
                n_bad++; $display("FAIL rnd_d_resp[%0d]: got v=%b e=%b d=%h want v=%b e=%b d=%h", i, d_rvalid, d_err, d_rdata, e_drv, e_der, e_drd);
            end
            if (e_fg) f_on = 0;
            if (e_dg) d_on = 0;
        end
        drive(1, 0, 0, 0, 0);
    endtask

`ifdef IMEM_ARB_STATS_EN
    task automatic test_stats();
        logic [31:0] fa = 32'h300;
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, fa, 1, 32'h400 + 32'(4 * (i / 5)));
            if (e_fg) fa += 4;
        end
        drive(1, 0, 0, 0, 0);
        n_cmp++;
        if (conflict_cnt !== 32'd10 || conflict_cnt !== 32'(conf_m)) begin
            n_bad++; $display("FAIL stats_conflict: got %0d want 10 (model %0d)", conflict_cnt, conf_m);
        end
        n_cmp++;
        if (forced_cnt !== 32'd2 || forced_cnt !== 32'(forced_m)) begin
            n_bad++; $display("FAIL stats_forced: got %0d want 2 (model %0d)", forced_cnt, forced_m);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_f_only();
        test_priority_burst();
        test_d_misaligned();
        test_back_to_back();
        test_reset_inflight();
        test_random();
`ifdef IMEM_ARB_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
Shares the single synchronous read port of the instruction memory between two requesters: instruction fetch (port F) and a data-side read of the code region (port D, e.g. loads of constants/literal pools). Fixed priority to F with an anti-starvation counter that guarantees D progress. Sits between the fetch stage/LSU and the instruction memory. Tracks the one-cycle memory latency and routes each response to its owner. Flags misaligned requests.

Parameters:
ADDR_W, 32, byte address width of both ports and of the memory port
DATA_W, 32, read data width
F_BURST_MAX, 4, max consecutive F grants while D is waiting before D is forced (range 1..255)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_ni  in  1  reset, synchronous, active-low
f_req_i  in  1  fetch request; held with f_addr_i until f_gnt_o
f_addr_i  in  ADDR_W  fetch byte address
f_gnt_o  out  1  fetch granted this cycle (combinational)
f_rvalid_o  out  1  fetch response valid, one-cycle pulse
f_rdata_o  out  DATA_W  fetch response data
f_err_o  out  1  fetch response is a misalignment error (valid with f_rvalid_o)
d_req_i  in  1  data request; held with d_addr_i until d_gnt_o
d_addr_i  in  ADDR_W  data byte address
d_gnt_o  out  1  data granted this cycle (combinational)
d_rvalid_o  out  1  data response valid, one-cycle pulse
d_rdata_o  out  DATA_W  data response data
d_err_o  out  1  data response is a misalignment error
mem_addr_o  out  ADDR_W  byte address to instruction memory read port
mem_data_i  in  DATA_W  memory read data, valid one cycle after mem_addr_o

Behaviour:
- Reset (rst_ni=0 at edge): starve counter=0, response owner=NONE, all rvalid/err=0, rdata=0. During reset cycles f_gnt_o=d_gnt_o=0, mem_addr_o=0. A response in flight at reset is dropped; no rvalid after reset release.
- Arbitration (combinational, per cycle, at most one grant): only F -> F; only D -> D; both -> F unless starve_cnt==F_BURST_MAX, then D; neither -> no grant, mem_addr_o=0.
- mem_addr_o = address of granted port, unchanged (no offset; memory handles base and out-of-range, returning 0).
- starve_cnt: +1 when D requests and F granted; cleared when D granted or d_req_i=0; saturates at F_BURST_MAX.
- Response pipeline: one register stage. Grant in cycle N -> rvalid on owner port in cycle N+1 with rdata=mem_data_i; other port rvalid=0. Back-to-back grants give back-to-back responses; throughput 1 request/cycle.
- Misalignment: addr[1:0]!=0 still granted; response in N+1 has err=1, rdata=0, memory data ignored.
- rdata outputs hold last value when rvalid=0; err cleared when rvalid=0.
- Requester changing addr while req held without grant: undefined (assertion in bench).
- States (owner register): NONE, F, D; next owner = granted port, else NONE.

Optional Feature:
IMEM_ARB_STATS_EN: when defined, adds outputs conflict_cnt_o (32 bit, cycles with f_req_i and d_req_i both high) and forced_cnt_o (32 bit, grants to D due to starve limit); both saturating at 0xFFFFFFFF, cleared by reset. When undefined, ports and counters absent; arbitration identical.

Test Plan:
- F only, f_addr=0x10 with mem returning 0xDEADBEEF -> f_gnt same cycle, f_rvalid next cycle, f_rdata=0xDEADBEEF, d_rvalid=0.
- F and D requesting continuously, F_BURST_MAX=4 -> grant pattern F,F,F,F,D repeating; starve_cnt back to 0 after D grant.
- D only, d_addr=0x22 -> d_gnt, next cycle d_rvalid=1, d_err=1, d_rdata=0.
- Alternating grants F@0x0, D@0x4, F@0x8 in consecutive cycles -> rvalid pulses on F,D,F in cycles +1..+3 with matching data; no gaps.
- Grant to F, rst_ni=0 next cycle -> no f_rvalid after reset release, all outputs 0 during reset.
- With IMEM_ARB_STATS_EN, 10 conflict cycles at F_BURST_MAX=4 -> conflict_cnt_o=10, forced_cnt_o=2.
